// File: rtl/set_bit_enum_pkg.sv
// Shared types and helpers for the set-bit enumerator: FSM state encoding,
// default word width and the per-bit range-mask predicate.
package set_bit_enum_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 64;

  // One bit of the inclusive [start_pos, end_pos] mask; start_pos > end_pos yields an empty mask.
  function automatic logic range_mask_bit(input int unsigned bit_pos,
                                          input int unsigned start_pos,
                                          input int unsigned end_pos);
    return (bit_pos >= start_pos) && (bit_pos <= end_pos);
  endfunction

endpackage

// File: rtl/set_bit_enumerator_lowest_set_bit.sv
// Combinational priority encoder: index of the lowest set bit of data,
// with found low (and idx zero) when data is all zeros.
module lowest_set_bit
  import set_bit_enum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (data[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end else begin
        idx   = idx;
        found = found;
      end
    end
  end

endmodule

// File: rtl/set_bit_enumerator.sv
// Enumerates, one beat per handshake, the ascending indices of set bits of a
// word within an inclusive range. Define SET_BIT_ENUM_COUNT_EN to add out_count.
module set_bit_enumerator
  import set_bit_enum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_start,
  input  logic [IDX_W-1:0]  in_end,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              out_none
`ifdef SET_BIT_ENUM_COUNT_EN
  ,
  output logic [IDX_W:0]    out_count
`endif
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] mask_s;
  logic [DATA_W-1:0] masked_s;
  logic [DATA_W-1:0] rem_next_s;
  logic [IDX_W-1:0]  low_idx_s;
  logic              low_found_s;
  logic              emit_s;
  logic              last_s;

  lowest_set_bit #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_lsb (
    .data  (rem_q),
    .idx   (low_idx_s),
    .found (low_found_s)
  );

  // Range mask built with full-width unsigned compares; no wrap-around.
  always_comb begin
    mask_s = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      mask_s[i] = range_mask_bit(i, 32'(in_start), 32'(in_end));
    end
  end

  assign masked_s   = in_data & mask_s;
  assign rem_next_s = rem_q & (rem_q - DATA_W'(1));
  assign emit_s     = (state_q == EMIT);
  assign last_s     = (rem_next_s == '0);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = emit_s;
  assign out_idx   = emit_s ? low_idx_s : '0;
  assign out_last  = emit_s && last_s;
  assign out_none  = emit_s && !low_found_s;

  // Next-state: capture the masked word on accept, clear one bit per accepted beat.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d   = masked_s;
          state_d = EMIT;
        end else begin
          rem_d   = rem_q;
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          rem_d   = rem_next_s;
          state_d = last_s ? IDLE : EMIT;
        end else begin
          rem_d   = rem_q;
          state_d = EMIT;
        end
      end
      default: begin
        rem_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and remaining-bits registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

`ifdef SET_BIT_ENUM_COUNT_EN
  logic [IDX_W:0] count_q, count_d;

  // Popcount is taken once at accept and held for the whole request.
  always_comb begin
    if (in_ready && in_valid) begin
      count_d = (IDX_W + 1)'($countones(masked_s));
    end else begin
      count_d = count_q;
    end
  end

  // Popcount register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;
`else
  // Count feature disabled: no popcount state or port.
`endif

endmodule

// File: tb/tb_set_bit_enumerator.sv
// Self-checking bench for set_bit_enumerator (DATA_W=64): table-driven
// requests plus directed stall, full-range and reset-mid-emission sequences.
module tb_set_bit_enumerator;

  localparam int DW = 64;
  localparam int IW = 6;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [IW-1:0] in_start;
  logic [IW-1:0] in_end;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_none;
`ifdef SET_BIT_ENUM_COUNT_EN
  logic [IW:0]   out_count;
`endif

  int n_checks;
  int n_fail;

  set_bit_enumerator #(.DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_start  (in_start),
    .in_end    (in_end),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_none  (out_none)
`ifdef SET_BIT_ENUM_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]      data;
    logic [5:0]       s;
    logic [5:0]       e;
    logic [3:0]       nb;
    logic [3:0][5:0]  idx;
    logic             none;
    logic [6:0]       cnt;
  } vec_t;

  function automatic vec_t mk(input logic [63:0] d, input logic [5:0] s, input logic [5:0] e,
                              input logic [3:0] nb, input logic [5:0] i0, input logic [5:0] i1,
                              input logic [5:0] i2, input logic [5:0] i3, input logic none,
                              input logic [6:0] cnt);
    vec_t v;
    v.data = d; v.s = s; v.e = e; v.nb = nb;
    v.idx[0] = i0; v.idx[1] = i1; v.idx[2] = i2; v.idx[3] = i3;
    v.none = none; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the block idle: drive one request, leave at the accept edge + 1.
  task automatic issue(input logic [63:0] d, input logic [5:0] s, input logic [5:0] e);
    check("in_ready_before_req", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_data = d; in_start = s; in_end = e;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Check one beat at the current negedge.
  task automatic beat(input string tag, input logic [5:0] idx, input logic last, input logic none);
    @(negedge clk);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_idx"},   {58'd0, out_idx},   {58'd0, idx});
    check({tag, "_last"},  {63'd0, out_last},  {63'd0, last});
    check({tag, "_none"},  {63'd0, out_none},  {63'd0, none});
    check({tag, "_inrdy"}, {63'd0, in_ready},  64'd0);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_idle_inrdy"}, {63'd0, in_ready},  64'd1);
  endtask

  vec_t vecs [7];

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_start = '0; in_end = '0; out_ready = 1'b1;

    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_idx",   {58'd0, out_idx},   64'd0);
    check("rst_out_last",  {63'd0, out_last},  64'd0);
    check("rst_out_none",  {63'd0, out_none},  64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
`ifdef SET_BIT_ENUM_COUNT_EN
    check("rst_count",     {57'd0, out_count}, 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    vecs[0] = mk(64'h91, 6'd0, 6'd63, 4'd3, 6'd0, 6'd4, 6'd7, 6'd0, 1'b0, 7'd3);
    vecs[1] = mk(64'hFF, 6'd2, 6'd5, 4'd4, 6'd2, 6'd3, 6'd4, 6'd5, 1'b0, 7'd4);
    vecs[2] = mk(64'h0F, 6'd8, 6'd15, 4'd1, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 7'd0);
    vecs[3] = mk(64'h0F, 6'd10, 6'd3, 4'd1, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1, 7'd0);
    vecs[4] = mk(64'h8000_0000_0000_0001, 6'd63, 6'd63, 4'd1, 6'd63, 6'd0, 6'd0, 6'd0, 1'b0, 7'd1);
    vecs[5] = mk(64'h8000_0000_0000_0001, 6'd0, 6'd63, 4'd2, 6'd0, 6'd63, 6'd0, 6'd0, 1'b0, 7'd2);
    vecs[6] = mk(64'h0000_0000_0000_0101, 6'd0, 6'd0, 4'd1, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 7'd1);

    for (int v = 0; v < 7; v++) begin
      issue(vecs[v].data, vecs[v].s, vecs[v].e);
      for (int b = 0; b < int'(vecs[v].nb); b++) begin
        beat($sformatf("vec%0d_b%0d", v, b), vecs[v].idx[b],
             (b == int'(vecs[v].nb) - 1), vecs[v].none);
`ifdef SET_BIT_ENUM_COUNT_EN
        check($sformatf("vec%0d_b%0d_count", v, b), {57'd0, out_count}, {57'd0, vecs[v].cnt});
`endif
      end
      idle_check($sformatf("vec%0d", v));
    end

    // Full range, all ones: 64 beats in order.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 6'd63);
    for (int b = 0; b < 64; b++) begin
      beat($sformatf("full_b%0d", b), 6'(b), (b == 63), 1'b0);
    end
    idle_check("full");

    // Backpressure: first beat held for 3 cycles, competing request ignored.
    issue(64'h30, 6'd0, 6'd63);
    out_ready = 1'b0;
    beat("stall_first", 6'd4, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 64'hFFFF; in_start = 6'd0; in_end = 6'd63;
    for (int c = 0; c < 3; c++) begin
      beat($sformatf("stall_hold%0d", c), 6'd4, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    beat("stall_second", 6'd5, 1'b1, 1'b0);
    idle_check("stall");
    idle_check("stall_nostale");

    // Reset asserted during the second beat.
    issue(64'hF, 6'd0, 6'd63);
    beat("rst_b0", 6'd0, 1'b0, 1'b0);
    beat("rst_b1", 6'd1, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_inrdy", {63'd0, in_ready},  64'd1);
    #1 reset = 1'b0;
    idle_check("rst_after0");
    idle_check("rst_after1");
    issue(64'h2, 6'd0, 6'd63);
    beat("post_rst", 6'd1, 1'b1, 1'b0);
    idle_check("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/set_bit_enumerator.md
Name: set_bit_enumerator

Overview:
- Sits directly downstream of the combinational "find first set bit within [start_range, end_range]" logic.
- Accepts one DATA_W-bit word plus an inclusive bit range over a valid/ready handshake.
- Emits, one per handshake, the index of every set bit inside that range, in ascending order.
- Feeds index-driven consumers such as per-lane dispatch and interrupt servicing.

Parameters:
- DATA_W, 64: width of the scanned word; must be 2 or greater.
- IDX_W, $clog2(DATA_W): width of the index and range fields; derived, do not override.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  DATA_W  word to scan.
- in_start  input  IDX_W  lowest bit of the range, inclusive.
- in_end  input  IDX_W  highest bit of the range, inclusive.
- out_valid  output  1  index beat valid.
- out_ready  input  1  consumer accepts the beat.
- out_idx  output  IDX_W  index of the current set bit.
- out_last  output  1  final beat of the current request.
- out_none  output  1  range contained no set bit (single-beat response).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, remaining vector=0.
  - out_valid=0, out_idx=0, out_last=0, out_none=0.
  - in_ready=1 (state is IDLE).
- States: IDLE and EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: register rem = in_data & mask(start,end), where mask sets bits start..end inclusive.
  - If in_start>in_end, the mask is all-zero.
  - Go to EMIT.
- EMIT:
  - in_ready=0; in_valid is ignored.
  - out_valid=1 and out_idx = lowest set bit of rem.
  - out_last = ((rem & (rem-1)) == 0).
  - When rem==0: out_none=1, out_last=1, out_idx=0.
  - On out_valid&&out_ready: rem <= rem & (rem-1). If out_last, go to IDLE.
- Latency and throughput:
  - Request accepted at edge T gives first out_valid at T+1.
  - One index per cycle under continuous out_ready.
  - in_ready reasserts the cycle after the last beat handshake; no same-cycle accept and emit.
- Stability: while out_valid && !out_ready, out_idx, out_last and out_none hold stable.
- Boundaries:
  - Bit 0 and bit DATA_W-1 are legal indices.
  - start==end gives a 1-bit range.
  - Full range 0..DATA_W-1 with all ones gives DATA_W beats.
- Reset mid-emission: out_valid deasserts asynchronously, pending indices are discarded, block returns to IDLE.
- Index arithmetic is unsigned. The mask is built with DATA_W-wide compares, with no wrap-around.

Optional Feature:
- Macro: SET_BIT_ENUM_COUNT_EN.
- When defined:
  - Adds output port out_count, width IDX_W+1: popcount of the masked word, registered at accept.
  - out_count is held constant across all beats of the request; it is 0 with out_none.
  - Resets to 0.
- When undefined: the port and its popcount logic are absent; all other behaviour is identical.

Decomposition:
- Package set_bit_enum_pkg holds:
  - typedef enum logic {IDLE, EMIT} state_t.
  - Default width constant DATA_W_DEF=64.
  - A function automatic for range-mask generation.
- Sub-module lowest_set_bit: combinational priority encoder, parameter DATA_W, outputs idx and found.
- Top level holds the FSM, the rem register, the handshakes and the optional popcount.

Test Plan (DATA_W=64):
- in_data=64'h91, start=0, end=63, out_ready=1 -> idx 0,4,7 at T+1..T+3; out_last only with 7; in_ready=1 at T+4.
- in_data=64'hFF, start=2, end=5 -> idx 2,3,4,5; out_last on 5; count=4 when SET_BIT_ENUM_COUNT_EN.
- in_data=64'h0F, start=8, end=15, and separately start=10, end=3 -> each gives one beat with out_none=1, out_last=1, idx=0.
- in_data=64'h8000_0000_0000_0001, start=63, end=63 -> single beat idx=63, out_last=1, out_none=0.
- in_data=64'h30, out_ready low for 3 cycles after the first beat -> idx=4 held stable; in_ready=0; new in_valid ignored. idx=5 follows once out_ready=1.
- reset pulsed during the second beat of in_data=64'hF -> out_valid=0 immediately; after release in_ready=1, no stale beats; a new request with 64'h2 gives idx=1 only.
